// File: rtl/led_pattern_sched.sv
// Timed LED pattern generator (blink/chase/bounce/count) with a prescaled step
// and a two-owner arbiter that lets an external requester take over F_LED.
module led_pattern_sched #(
  parameter int unsigned STEP_CYCLES = 25000000
) (
  input  logic       FPGA_CLK,
  input  logic       FPGA_RST,
  input  logic       mode_next,
  input  logic       ovr_req,
  input  logic [3:0] ovr_pattern,
  output logic       ovr_gnt,
  output logic [1:0] mode,
  output logic       step_tick,
  output logic [4:1] F_LED
);

  typedef enum logic {OWN_PAT = 1'b0, OWN_OVR = 1'b1} own_t;

  localparam logic [31:0] CNT_LAST = 32'(STEP_CYCLES - 1);

  own_t        state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [3:0]  pat, pat_nxt, led_nxt;
  logic        dir_up, dir_up_nxt;
  logic [1:0]  mode_nxt;
  logic        gnt_nxt, tick_nxt;

  function automatic logic [3:0] entry_pat(input logic [1:0] m);
    return (m == 2'd1 || m == 2'd2) ? 4'b0001 : 4'b0000;
  endfunction

  // Returns {direction_up, next_pattern}; only BOUNCE ever changes direction.
  function automatic logic [4:0] step_pat(input logic [1:0] m, input logic [3:0] p,
                                          input logic up);
    logic [4:0] r;
    r = {up, p};
    case (m)
      2'd0: r = {up, ~p};
      2'd1: r = {up, p[2:0], p[3]};
      2'd2: begin
        if (up)
          r = (p == 4'b1000) ? {1'b0, 4'b0100} : {1'b1, p[2:0], 1'b0};
        else
          r = (p == 4'b0001) ? {1'b1, 4'b0010} : {1'b0, 1'b0, p[3:1]};
      end
      default: r = {up, p + 4'd1};
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pat_nxt    = pat;
    dir_up_nxt = dir_up;
    mode_nxt   = mode;
    gnt_nxt    = ovr_gnt;
    tick_nxt   = 1'b0;
    led_nxt    = pat;
    case (state)
      OWN_PAT: begin
        if (mode_next) begin
          // A mode change restarts the step and swallows any coinciding step.
          mode_nxt   = mode + 2'd1;
          pat_nxt    = entry_pat(mode_nxt);
          cnt_nxt    = '0;
          dir_up_nxt = 1'b1;
          led_nxt    = pat_nxt;
        end else if (!ovr_req) begin
          if (cnt == CNT_LAST) begin
            cnt_nxt               = '0;
            {dir_up_nxt, pat_nxt} = step_pat(mode, pat, dir_up);
            tick_nxt              = 1'b1;
          end else begin
            cnt_nxt = cnt + 32'd1;
          end
          led_nxt = pat_nxt;
        end
        if (ovr_req) begin
          state_nxt = OWN_OVR;
          gnt_nxt   = 1'b1;
          led_nxt   = ovr_pattern;
        end
      end
      OWN_OVR: begin
        if (ovr_req) begin
          led_nxt = ovr_pattern;
        end else begin
          state_nxt = OWN_PAT;
          gnt_nxt   = 1'b0;
          led_nxt   = pat;
        end
      end
    endcase
  end

  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      state     <= OWN_PAT;
      cnt       <= '0;
      pat       <= '0;
      dir_up    <= 1'b1;
      mode      <= '0;
      ovr_gnt   <= 1'b0;
      step_tick <= 1'b0;
      F_LED     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pat       <= pat_nxt;
      dir_up    <= dir_up_nxt;
      mode      <= mode_nxt;
      ovr_gnt   <= gnt_nxt;
      step_tick <= tick_nxt;
      F_LED     <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_sched.sv
// Bench for led_pattern_sched: directed scenarios plus random traffic, checked
// against a table-driven model (pattern index per mode) updated once per edge.
module tb_led_pattern_sched;

  localparam int STEP = 4;

  logic       FPGA_CLK;
  logic       FPGA_RST;
  logic       mode_next;
  logic       ovr_req;
  logic [3:0] ovr_pattern;
  logic       ovr_gnt;
  logic [1:0] mode;
  logic       step_tick;
  logic [4:1] F_LED;

  led_pattern_sched #(.STEP_CYCLES(STEP)) dut (
    .FPGA_CLK   (FPGA_CLK),
    .FPGA_RST   (FPGA_RST),
    .mode_next  (mode_next),
    .ovr_req    (ovr_req),
    .ovr_pattern(ovr_pattern),
    .ovr_gnt    (ovr_gnt),
    .mode       (mode),
    .step_tick  (step_tick),
    .F_LED      (F_LED)
  );

  initial FPGA_CLK = 1'b0;
  always #5 FPGA_CLK = ~FPGA_CLK;

  int checks = 0;
  int passes = 0;

  int         m_mode, m_idx, m_cnt;
  bit         m_gnt, m_tick;
  logic [3:0] m_led;
  logic [3:0] bounce_tbl [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};

  function automatic int seq_len(int m);
    case (m)
      0: return 2;
      1: return 4;
      2: return 6;
      default: return 16;
    endcase
  endfunction

  function automatic logic [3:0] seq(int m, int i);
    case (m)
      0: return (i % 2 == 1) ? 4'b1111 : 4'b0000;
      1: return 4'(1 << i);
      2: return bounce_tbl[i];
      default: return 4'(i);
    endcase
  endfunction

  task automatic model_edge();
    if (FPGA_RST) begin
      m_mode = 0; m_idx = 0; m_cnt = 0; m_gnt = 0; m_tick = 0; m_led = 4'b0000;
    end else if (!m_gnt) begin
      m_tick = 0;
      if (mode_next) begin
        m_mode = (m_mode + 1) % 4; m_idx = 0; m_cnt = 0;
        m_led  = seq(m_mode, 0);
      end else if (!ovr_req) begin
        if (m_cnt == STEP - 1) begin
          m_cnt = 0; m_idx = (m_idx + 1) % seq_len(m_mode); m_tick = 1;
        end else begin
          m_cnt++;
        end
        m_led = seq(m_mode, m_idx);
      end
      if (ovr_req) begin
        m_gnt = 1; m_led = ovr_pattern;
      end
    end else begin
      m_tick = 0;
      if (ovr_req) m_led = ovr_pattern;
      else begin
        m_gnt = 0; m_led = seq(m_mode, m_idx);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge FPGA_CLK);
    #1;
  endtask

  task automatic test_reset();
    FPGA_RST = 1'b1; mode_next = 1'b0; ovr_req = 1'b0; ovr_pattern = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (F_LED !== 4'b0000 || mode !== 2'd0 || ovr_gnt !== 1'b0 || step_tick !== 1'b0)
        $display("FAIL reset cyc=%0d: got led=%b mode=%0d gnt=%b tick=%b, want 0000/0/0/0",
                 i, F_LED, mode, ovr_gnt, step_tick);
      else passes++;
    end
    FPGA_RST = 1'b0;
  endtask

  task automatic test_blink();
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if (F_LED !== m_led || mode !== 2'(m_mode) || ovr_gnt !== m_gnt || step_tick !== m_tick)
        $display("FAIL blink cyc=%0d: got led=%b mode=%0d gnt=%b tick=%b, want led=%b mode=%0d gnt=%b tick=%b",
                 i, F_LED, mode, ovr_gnt, step_tick, m_led, m_mode, m_gnt, m_tick);
      else passes++;
    end
  endtask

  task automatic test_chase_bounce();
    mode_next = 1'b1; tick(); mode_next = 1'b0;
    checks++;
    if (mode !== 2'd1 || F_LED !== 4'b0001 || step_tick !== 1'b0)
      $display("FAIL chase_entry: got mode=%0d led=%b tick=%b, want 1/0001/0", mode, F_LED, step_tick);
    else passes++;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (F_LED !== m_led || mode !== 2'(m_mode) || ovr_gnt !== m_gnt || step_tick !== m_tick)
        $display("FAIL chase cyc=%0d: got led=%b mode=%0d gnt=%b tick=%b, want led=%b mode=%0d gnt=%b tick=%b",
                 i, F_LED, mode, ovr_gnt, step_tick, m_led, m_mode, m_gnt, m_tick);
      else passes++;
    end
    mode_next = 1'b1; tick(); mode_next = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++;
      if (F_LED !== m_led || mode !== 2'(m_mode) || ovr_gnt !== m_gnt || step_tick !== m_tick)
        $display("FAIL bounce cyc=%0d: got led=%b mode=%0d gnt=%b tick=%b, want led=%b mode=%0d gnt=%b tick=%b",
                 i, F_LED, mode, ovr_gnt, step_tick, m_led, m_mode, m_gnt, m_tick);
      else passes++;
    end
  endtask

  task automatic test_count_wrap();
    bit found;
    mode_next = 1'b1; tick(); mode_next = 1'b0;
    for (int i = 0; i < 17 * STEP; i++) begin
      tick();
      checks++;
      if (F_LED !== m_led || mode !== 2'(m_mode) || ovr_gnt !== m_gnt || step_tick !== m_tick)
        $display("FAIL count cyc=%0d: got led=%b mode=%0d gnt=%b tick=%b, want led=%b mode=%0d gnt=%b tick=%b",
                 i, F_LED, mode, ovr_gnt, step_tick, m_led, m_mode, m_gnt, m_tick);
      else passes++;
    end
    found = 0;
    for (int i = 0; i < 2 * STEP && !found; i++) begin
      if (m_cnt == STEP - 1) found = 1;
      else tick();
    end
    checks++;
    if (!found) $display("FAIL count_wait: got no cnt==%0d within bound, want one", STEP - 1);
    else passes++;
    mode_next = 1'b1; tick(); mode_next = 1'b0;
    checks++;
    if (mode !== 2'd0 || F_LED !== 4'b0000 || step_tick !== 1'b0)
      $display("FAIL mode_beats_step: got mode=%0d led=%b tick=%b, want 0/0000/0", mode, F_LED, step_tick);
    else passes++;
    for (int i = 0; i < 2 * STEP; i++) begin
      tick();
      checks++;
      if (F_LED !== m_led || mode !== 2'(m_mode) || ovr_gnt !== m_gnt || step_tick !== m_tick)
        $display("FAIL after_wrap cyc=%0d: got led=%b mode=%0d gnt=%b tick=%b, want led=%b mode=%0d gnt=%b tick=%b",
                 i, F_LED, mode, ovr_gnt, step_tick, m_led, m_mode, m_gnt, m_tick);
      else passes++;
    end
  endtask

  task automatic test_override();
    bit found;
    mode_next = 1'b1; tick(); mode_next = 1'b0;
    found = 0;
    for (int i = 0; i < 8 * STEP && !found; i++) begin
      if (m_led == 4'b0100 && m_cnt == 1) found = 1;
      else tick();
    end
    checks++;
    if (!found) $display("FAIL ovr_wait: got no 0100 at cnt 1 within bound, want one");
    else passes++;
    ovr_req = 1'b1; ovr_pattern = 4'b1010;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) ovr_pattern = 4'b0110;
      tick();
      checks++;
      if (ovr_gnt !== 1'b1 || step_tick !== 1'b0 || F_LED !== ((i < 5) ? 4'b1010 : 4'b0110))
        $display("FAIL ovr_grant cyc=%0d: got gnt=%b led=%b tick=%b, want 1/%b/0",
                 i, ovr_gnt, F_LED, step_tick, (i < 5) ? 4'b1010 : 4'b0110);
      else passes++;
    end
    ovr_req = 1'b0; tick();
    checks++;
    if (ovr_gnt !== 1'b0 || F_LED !== 4'b0100 || mode !== 2'd1)
      $display("FAIL ovr_release: got gnt=%b led=%b mode=%0d, want 0/0100/1", ovr_gnt, F_LED, mode);
    else passes++;
    for (int i = 0; i < 2 * STEP; i++) begin
      tick();
      checks++;
      if (F_LED !== m_led || mode !== 2'(m_mode) || ovr_gnt !== m_gnt || step_tick !== m_tick)
        $display("FAIL ovr_resume cyc=%0d: got led=%b mode=%0d gnt=%b tick=%b, want led=%b mode=%0d gnt=%b tick=%b",
                 i, F_LED, mode, ovr_gnt, step_tick, m_led, m_mode, m_gnt, m_tick);
      else passes++;
    end
  endtask

  task automatic test_grant_mode_reset();
    logic [1:0] mode_before;
    mode_before = mode;
    ovr_req = 1'b1; ovr_pattern = 4'b1001;
    tick(); tick();
    mode_next = 1'b1; tick(); mode_next = 1'b0;
    tick();
    ovr_req = 1'b0; tick();
    checks++;
    if (mode !== mode_before || ovr_gnt !== 1'b0 || F_LED !== m_led)
      $display("FAIL mode_in_grant: got mode=%0d gnt=%b led=%b, want %0d/0/%b",
               mode, ovr_gnt, F_LED, mode_before, m_led);
    else passes++;
    ovr_req = 1'b1; ovr_pattern = 4'b1111;
    tick(); tick(); tick();
    FPGA_RST = 1'b1; tick();
    checks++;
    if (ovr_gnt !== 1'b0 || F_LED !== 4'b0000 || mode !== 2'd0 || step_tick !== 1'b0)
      $display("FAIL reset_in_grant: got gnt=%b led=%b mode=%0d tick=%b, want 0/0000/0/0",
               ovr_gnt, F_LED, mode, step_tick);
    else passes++;
    FPGA_RST = 1'b0; tick();
    checks++;
    if (ovr_gnt !== 1'b1 || F_LED !== 4'b1111)
      $display("FAIL regrant: got gnt=%b led=%b, want 1/1111", ovr_gnt, F_LED);
    else passes++;
    ovr_req = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      FPGA_RST    = ($urandom_range(0, 99) == 0);
      mode_next   = ($urandom_range(0, 7) == 0);
      if (i >= 300 && i < 340) ovr_req = ~ovr_req;
      else if ($urandom_range(0, 9) == 0) ovr_req = ~ovr_req;
      ovr_pattern = 4'($urandom);
      tick();
      checks++;
      if (F_LED !== m_led || mode !== 2'(m_mode) || ovr_gnt !== m_gnt || step_tick !== m_tick)
        $display("FAIL random cyc=%0d: got led=%b mode=%0d gnt=%b tick=%b, want led=%b mode=%0d gnt=%b tick=%b",
                 i, F_LED, mode, ovr_gnt, step_tick, m_led, m_mode, m_gnt, m_tick);
      else passes++;
    end
    FPGA_RST = 1'b0; mode_next = 1'b0; ovr_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_blink();
    test_chase_bounce();
    test_count_wrap();
    test_override();
    test_grant_mode_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of run by 200000, want earlier finish");
    $fatal(1, "timeout");
  end

endmodule
